// File: rtl/divider_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// divider_arbiter_pkg
// Shared definitions for the divider arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   - STAT_DZ / STAT_TO : bit positions inside a requester's 2-bit status
//   - STATUS_* : complete 2-bit status words written into a response slot
//   - sat_pos / sat_neg : saturated divide-by-zero results for a given width,
//     returned in a MAX_WIDTH container; callers keep the low WIDTH bits.
// -----------------------------------------------------------------------------
package divider_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int STAT_DZ = 0;
    localparam int STAT_TO = 1;

    localparam logic [1:0] STATUS_OK = 2'b00;
    localparam logic [1:0] STATUS_DZ = 2'(1 << STAT_DZ);
    localparam logic [1:0] STATUS_TO = 2'(1 << STAT_TO);

    // Widest operand the saturation helpers can describe.
    localparam int MAX_WIDTH = 64;

    // Largest positive two's-complement value of 'width' bits (0111...1).
    function automatic logic [MAX_WIDTH-1:0] sat_pos(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (b < width - 1) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

    // Most negative two's-complement value of 'width' bits (1000...0).
    function automatic logic [MAX_WIDTH-1:0] sat_neg(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (b == width - 1) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: starting at ptr_i and wrapping modulo N,
// find the first set bit of eligible_i.
// Ports:
//   eligible_i    in  N      candidate requesters
//   ptr_i         in  IDX_W  search start index (must be < N)
//   grant_o       out N      one-hot grant (all zero when nothing eligible)
//   grant_idx_o   out IDX_W  index of the granted requester
//   grant_valid_o out 1      at least one requester is eligible
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    // cand_idx[k] is the requester examined k-th in the search order.
    logic [IDX_W-1:0] cand_idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr_i} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ?
                                  IDX_W'(sum - (IDX_W+1)'(N)) : sum[IDX_W-1:0];
        end
    endgenerate

    // Walk from the farthest candidate back to the nearest so the nearest
    // eligible one is the last (winning) assignment.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible_i[cand_idx[k]]) begin
                grant_idx_o   = cand_idx[k];
                grant_valid_o = 1'b1;
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// -----------------------------------------------------------------------------
// divider_arbiter
// Shares one external iterative divider among NREQ requesters with
// round-robin selection. Divide-by-zero is answered locally with a saturated
// result; a watchdog resets the divider if a divide never completes.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   req_valid/N/D   per-requester request and operands (slice i*WIDTH)
//   req_ready       one-cycle pulse: operands of that requester captured
//   rsp_valid/ready per-requester held response handshake
//   rsp_data        per-requester result (divider output format)
//   rsp_status      per-requester {timeout, divide-by-zero}
//   div_N/div_D     registered operands to the divider
//   div_in_valid    divider start pulse
//   div_rst         active-high divider reset (high during rst, watchdog pulse)
//   div_ready, div_out_valid, div_out   divider handshake and result
// -----------------------------------------------------------------------------
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_N,
    input  logic [NREQ*WIDTH-1:0] req_D,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*WIDTH-1:0] rsp_data,
    output logic [2*NREQ-1:0]     rsp_status,
    output logic [WIDTH-1:0]      div_N,
    output logic [WIDTH-1:0]      div_D,
    output logic                  div_in_valid,
    output logic                  div_rst,
    input  logic                  div_ready,
    input  logic                  div_out_valid,
    input  logic [WIDTH-1:0]      div_out
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [MAX_WIDTH-1:0] SAT_POS_FULL = sat_pos(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SAT_NEG_FULL = sat_neg(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];

    arb_state_e         state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   owner_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic [NREQ-1:0]    req_ready_q;
    logic [NREQ-1:0]    rsp_valid_q;
    logic [2*NREQ-1:0]  rsp_status_q;
    logic [WIDTH-1:0]   rsp_data_q [NREQ];
    logic [WIDTH-1:0]   div_n_q;
    logic [WIDTH-1:0]   div_d_q;
    logic               div_in_valid_q;
    logic               div_rst_q;

    logic [WIDTH-1:0]   req_n_s [NREQ];
    logic [WIDTH-1:0]   req_d_s [NREQ];
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [WIDTH-1:0]   sel_n;
    logic [WIDTH-1:0]   sel_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign req_n_s[gi] = req_N[gi*WIDTH +: WIDTH];
            assign req_d_s[gi] = req_D[gi*WIDTH +: WIDTH];
            assign rsp_data[gi*WIDTH +: WIDTH] = rsp_data_q[gi];
        end
    endgenerate

    // A requester whose previous result is still held is not served again.
    assign eligible = req_valid & ~rsp_valid_q;

    rr_picker #(
        .N     (NREQ),
        .IDX_W (PTR_W)
    ) u_picker (
        .eligible_i    (eligible),
        .ptr_i         (ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign sel_n      = req_n_s[grant_idx];
    assign sel_d      = req_d_s[grant_idx];
    assign ptr_d      = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign wait_cnt_d = wait_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            owner_q        <= '0;
            wait_cnt_q     <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_status_q   <= '0;
            div_n_q        <= '0;
            div_d_q        <= '0;
            div_in_valid_q <= 1'b0;
            div_rst_q      <= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else begin
            req_ready_q    <= '0;
            div_in_valid_q <= 1'b0;
            div_rst_q      <= 1'b0;
            // Consumed responses drop; a slot being filled below is always
            // empty, so the set never collides with this clear.
            rsp_valid_q    <= rsp_valid_q & ~rsp_ready;

            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        req_ready_q <= grant;
                        ptr_q       <= ptr_d;
                        if (sel_d == '0) begin
                            // Answered locally: the divider would never converge.
                            rsp_data_q[grant_idx]             <= sel_n[WIDTH-1] ? SAT_NEG : SAT_POS;
                            rsp_status_q[2*grant_idx +: 2]    <= STATUS_DZ;
                            rsp_valid_q[grant_idx]            <= 1'b1;
                        end else begin
                            div_n_q <= sel_n;
                            div_d_q <= sel_d;
                            owner_q <= grant_idx;
                            state_q <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (div_ready) begin
                        div_in_valid_q <= 1'b1;
                        wait_cnt_q     <= '0;
                        state_q        <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Result takes priority over a watchdog expiring the same cycle.
                    if (div_out_valid) begin
                        rsp_data_q[owner_q]            <= div_out;
                        rsp_status_q[2*owner_q +: 2]   <= STATUS_OK;
                        rsp_valid_q[owner_q]           <= 1'b1;
                        state_q                        <= ST_IDLE;
                    end else if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
                        rsp_data_q[owner_q]            <= '0;
                        rsp_status_q[2*owner_q +: 2]   <= STATUS_TO;
                        rsp_valid_q[owner_q]           <= 1'b1;
                        div_rst_q                      <= 1'b1;
                        state_q                        <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = rsp_status_q;
    assign div_N        = div_n_q;
    assign div_D        = div_d_q;
    assign div_in_valid = div_in_valid_q;
    assign div_rst      = div_rst_q;

endmodule
